// File: rtl/clock_pkg.sv
// Shared definitions for the mm:ss countdown timer: FSM state encoding,
// BCD digit limits and a two-digit BCD increment helper.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX1  = 4'd9;
    localparam logic [3:0] BCD_MAX10 = 4'd5;

    // Increment a {tens, ones} BCD pair in the 00..59 range; 59 wraps to 00.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] pair);
        logic [7:0] res;
        if (pair[3:0] == BCD_MAX1) begin
            if (pair[7:4] == BCD_MAX10) begin
                res = 8'h00;
            end else begin
                res = {pair[7:4] + 4'd1, 4'd0};
            end
        end else begin
            res = {pair[7:4], pair[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_mmss_updown.sv
// Four-digit mm:ss BCD register with clear, borrow-chained decrement and
// independent no-carry increments of the seconds and minutes fields.
module bcd_mmss_updown
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       dec,
    input  logic       inc_sec,
    input  logic       inc_min,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       zero_next
);

    logic [3:0] sec1_r, sec10_r, min1_r, min10_r;
    logic [3:0] sec1_s, sec10_s, min1_s, min10_s;

    // Next-digit selection: clear beats decrement beats the increments.
    always_comb begin
        sec1_s  = sec1_r;
        sec10_s = sec10_r;
        min1_s  = min1_r;
        min10_s = min10_r;
        if (clr) begin
            sec1_s  = 4'd0;
            sec10_s = 4'd0;
            min1_s  = 4'd0;
            min10_s = 4'd0;
        end else if (dec) begin
            if (sec1_r != 4'd0) begin
                sec1_s = sec1_r - 4'd1;
            end else begin
                sec1_s = BCD_MAX1;
                if (sec10_r != 4'd0) begin
                    sec10_s = sec10_r - 4'd1;
                end else begin
                    sec10_s = BCD_MAX10;
                    if (min1_r != 4'd0) begin
                        min1_s = min1_r - 4'd1;
                    end else begin
                        min1_s = BCD_MAX1;
                        if (min10_r != 4'd0) begin
                            min10_s = min10_r - 4'd1;
                        end else begin
                            min10_s = BCD_MAX10;
                        end
                    end
                end
            end
        end else begin
            if (inc_sec) begin
                {sec10_s, sec1_s} = bcd_inc_wrap({sec10_r, sec1_r});
            end else begin
                {sec10_s, sec1_s} = {sec10_r, sec1_r};
            end
            if (inc_min) begin
                {min10_s, min1_s} = bcd_inc_wrap({min10_r, min1_r});
            end else begin
                {min10_s, min1_s} = {min10_r, min1_r};
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec1_r  <= 4'd0;
            sec10_r <= 4'd0;
            min1_r  <= 4'd0;
            min10_r <= 4'd0;
        end else begin
            sec1_r  <= sec1_s;
            sec10_r <= sec10_s;
            min1_r  <= min1_s;
            min10_r <= min10_s;
        end
    end

    assign sec1  = sec1_r;
    assign sec10 = sec10_r;
    assign min1  = min1_r;
    assign min10 = min10_r;

    // A decrement from 00:01 is the only one that lands on 00:00.
    assign zero_next = (min10_r == 4'd0) && (min1_r == 4'd0) &&
                       (sec10_r == 4'd0) && (sec1_r == 4'd1);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Kitchen-timer controller: sequences the mm:ss register through set, run,
// pause and alarm phases from button pulses and a 1 s tick.
module countdown_timer_ctrl
    import clock_pkg::*;
#(
    parameter int ALARM_SEC = 10,
    parameter int TICK_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_sec,
    input  logic       btn_start,
    input  logic       btn_inc_sec,
    input  logic       btn_inc_min,
    input  logic       btn_clear,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam logic [TICK_W-1:0] ALARM_LAST = TICK_W'(ALARM_SEC - 1);

    state_t            state_r, state_s;
    logic [TICK_W-1:0] cnt_r, cnt_s;
    logic              running_r, alarm_r;
    logic              clr_s, dec_s, inc_sec_s, inc_min_s;
    logic              zero_next_s, time_zero_s;

    bcd_mmss_updown u_digits (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr_s),
        .dec       (dec_s),
        .inc_sec   (inc_sec_s),
        .inc_min   (inc_min_s),
        .sec1      (sec1),
        .sec10     (sec10),
        .min1      (min1),
        .min10     (min10),
        .zero_next (zero_next_s)
    );

    assign time_zero_s = (sec1 == 4'd0) && (sec10 == 4'd0) &&
                         (min1 == 4'd0) && (min10 == 4'd0);

    // Next state, alarm counter and digit-register commands.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        clr_s     = 1'b0;
        dec_s     = 1'b0;
        inc_sec_s = 1'b0;
        inc_min_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_clear) begin
                    clr_s = 1'b1;
                end else if (btn_start) begin
                    if (!time_zero_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    inc_sec_s = btn_inc_sec;
                    inc_min_s = btn_inc_min;
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    clr_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (clk_sec) begin
                    // The tick is applied even alongside start; reaching zero wins.
                    dec_s = 1'b1;
                    if (zero_next_s) begin
                        state_s = ST_ALARM;
                        cnt_s   = {TICK_W{1'b0}};
                    end else if (btn_start) begin
                        state_s = ST_PAUSE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (btn_start) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    clr_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (btn_start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                if (btn_clear || btn_start || btn_inc_sec || btn_inc_min) begin
                    clr_s   = btn_clear;
                    state_s = ST_IDLE;
                end else if (clk_sec) begin
                    if (cnt_r == ALARM_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_ALARM;
                end
            end
            default: begin
                state_s = ST_IDLE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // State, alarm counter and flag registers; flags track the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {TICK_W{1'b0}};
            running_r <= 1'b0;
            alarm_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            running_r <= (state_s == ST_RUN);
            alarm_r   <= (state_s == ST_ALARM);
        end
    end

    assign running = running_r;
    assign alarm   = alarm_r;
    assign state   = state_r;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus random stimulus,
// all checked against a seconds-count reference model every cycle.
module tb_countdown_timer_ctrl;

    localparam int ALARM_SEC = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_sec = 1'b0, btn_start = 1'b0, btn_inc_sec = 1'b0;
    logic       btn_inc_min = 1'b0, btn_clear = 1'b0;
    logic [3:0] sec1, sec10, min1, min10;
    logic       running, alarm;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: minutes and seconds as plain integers.
    int m_min = 0, m_sec = 0, m_st = M_IDLE, m_cnt = 0;

    countdown_timer_ctrl #(.ALARM_SEC(ALARM_SEC), .TICK_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec), .btn_start(btn_start),
        .btn_inc_sec(btn_inc_sec), .btn_inc_min(btn_inc_min), .btn_clear(btn_clear),
        .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
        .running(running), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_st = M_IDLE; m_cnt = 0;
    endtask

    task automatic model_step(input bit clr, input bit st, input bit is, input bit im, input bit tk);
        int total;
        total = m_min * 60 + m_sec;
        case (m_st)
            M_IDLE: begin
                if (clr) begin m_min = 0; m_sec = 0; end
                else if (st) begin if (total != 0) m_st = M_RUN; end
                else begin
                    if (is) m_sec = (m_sec + 1) % 60;
                    if (im) m_min = (m_min + 1) % 60;
                end
            end
            M_RUN: begin
                if (clr) begin m_min = 0; m_sec = 0; m_st = M_IDLE; end
                else begin
                    if (tk) begin
                        total = total - 1;
                        m_min = total / 60;
                        m_sec = total % 60;
                    end
                    if (tk && total == 0) begin m_st = M_ALARM; m_cnt = 0; end
                    else if (st) m_st = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (clr) begin m_min = 0; m_sec = 0; m_st = M_IDLE; end
                else if (st) m_st = M_RUN;
            end
            default: begin
                if (clr || st || is || im) m_st = M_IDLE;
                else if (tk) begin
                    m_cnt++;
                    if (m_cnt == ALARM_SEC) m_st = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".digits"}, 32'({min10, min1, sec10, sec1}), 32'(model_digits()));
        check({tag, ".state"}, 32'(state), 32'(m_st));
        check({tag, ".running"}, 32'(running), 32'(m_st == M_RUN));
        check({tag, ".alarm"}, 32'(alarm), 32'(m_st == M_ALARM));
    endtask

    // One clock cycle with the given pulses; called from posedge+1.
    task automatic cycle(input bit clr, input bit st, input bit is, input bit im, input bit tk);
        btn_clear = clr; btn_start = st; btn_inc_sec = is; btn_inc_min = im; clk_sec = tk;
        @(posedge clk);
        model_step(clr, st, is, im, tk);
        #1;
        btn_clear = 1'b0; btn_start = 1'b0; btn_inc_sec = 1'b0;
        btn_inc_min = 1'b0; clk_sec = 1'b0;
        compare_model("cyc");
    endtask

    task automatic repeat_cycle(input int n, input bit clr, input bit st, input bit is,
                                input bit im, input bit tk);
        for (int i = 0; i < n; i++) cycle(clr, st, is, im, tk);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset.digits", 32'({min10, min1, sec10, sec1}), 32'h0);
        check("reset.state", 32'(state), 32'(M_IDLE));
        check("reset.flags", 32'({running, alarm}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        bit c, s, i1, i2, t;
        repeat (2) @(posedge clk);
        #1;
        check("por.digits", 32'({min10, min1, sec10, sec1}), 32'h0);
        check("por.state", 32'(state), 32'(M_IDLE));
        check("por.flags", 32'({running, alarm}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Set 03:05.
        repeat_cycle(3, 0, 0, 0, 1, 0);
        repeat_cycle(5, 0, 0, 1, 0, 0);
        check("set.digits", 32'({min10, min1, sec10, sec1}), 32'h0305);
        check("set.running", 32'(running), 32'h0);

        // Wraps, including a simultaneous sec+min press and an ignored tick.
        cycle(1, 0, 0, 0, 0);
        repeat_cycle(60, 0, 0, 1, 0, 0);
        check("wrap.sec", 32'({min10, min1, sec10, sec1}), 32'h0000);
        repeat_cycle(59, 0, 0, 0, 1, 1);
        check("wrap.min59", 32'({min10, min1, sec10, sec1}), 32'h5900);
        cycle(0, 0, 1, 1, 0);
        check("wrap.both", 32'({min10, min1, sec10, sec1}), 32'h0001);

        // Countdown 01:00 with borrow, then the alarm window.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("borrow.digits", 32'({min10, min1, sec10, sec1}), 32'h0059);
        check("borrow.running", 32'(running), 32'h1);
        repeat_cycle(59, 0, 0, 0, 0, 1);
        check("expire.state", 32'(state), 32'(M_ALARM));
        check("expire.alarm", 32'(alarm), 32'h1);
        repeat_cycle(ALARM_SEC - 1, 0, 0, 0, 0, 1);
        check("alarm.held", 32'(alarm), 32'h1);
        cycle(0, 0, 0, 0, 1);
        check("alarm.end", 32'({state, alarm}), 32'({2'(M_IDLE), 1'b0}));

        // Pause at 00:30.
        repeat_cycle(30, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("pause.state", 32'(state), 32'(M_PAUSE));
        repeat_cycle(5, 0, 0, 0, 0, 1);
        check("pause.frozen", 32'({min10, min1, sec10, sec1}), 32'h0030);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("resume.digits", 32'({min10, min1, sec10, sec1}), 32'h0029);

        // Start+tick at 00:01 -> ALARM; clear+tick at 00:20 -> IDLE.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        check("simul.alarm", 32'(state), 32'(M_ALARM));
        cycle(1, 0, 0, 0, 0);
        repeat_cycle(20, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        check("simul.clear", 32'({state, min10, min1, sec10, sec1}), 32'h0);

        // Start at 00:00 ignored; inc during ALARM exits without changing digits.
        cycle(0, 1, 0, 0, 0);
        check("start.zero", 32'(state), 32'(M_IDLE));
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check("alarm.inc", 32'({state, min10, min1, sec10, sec1}), 32'h0);

        // Reset mid-RUN at 02:15.
        repeat_cycle(2, 0, 0, 0, 1, 0);
        repeat_cycle(15, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("prereset.run", 32'(running), 32'h1);
        async_reset();
        compare_model("postreset");

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            r  = $urandom_range(999);
            c  = ($urandom_range(59) == 0);
            s  = ($urandom_range(11) == 0);
            i1 = ($urandom_range(4) == 0);
            i2 = ($urandom_range(7) == 0);
            t  = ($urandom_range(2) == 0);
            if (r < 2) async_reset();
            else cycle(c, s, i1, i2, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Controller for a mm:ss kitchen-style countdown timer.
- Owns a 4-digit BCD time register and sequences it through set, run, pause and alarm phases, driven by single-cycle button pulses and a 1 s tick from the existing clock-divider chain.
- Digit outputs feed the FND display path.
- The alarm flag drives an LED or buzzer.

Parameters:
- ALARM_SEC, 10, number of clk_sec ticks the alarm stays asserted before auto-return to IDLE (1..255).
- TICK_W, 8, width of the alarm tick counter; must hold ALARM_SEC.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous active-low reset
- clk_sec  in  1  one-cycle pulse, once per second
- btn_start  in  1  one-cycle pulse; start/pause toggle
- btn_inc_sec  in  1  one-cycle pulse; seconds +1 in IDLE
- btn_inc_min  in  1  one-cycle pulse; minutes +1 in IDLE
- btn_clear  in  1  one-cycle pulse; abort and zero
- sec1  out  4  BCD seconds ones (0..9)
- sec10  out  4  BCD seconds tens (0..5)
- min1  out  4  BCD minutes ones (0..9)
- min10  out  4  BCD minutes tens (0..5)
- running  out  1  high in RUN
- alarm  out  1  high in ALARM
- state  out  2  current FSM state

Behaviour:
- Reset (reset_n low, asynchronous): all digits 0, state IDLE, running 0, alarm 0, alarm counter 0. Reset mid-RUN or mid-ALARM aborts immediately.
- All outputs are registered. Every effect appears on the clock edge at which the triggering pulse is sampled, so it is visible the following cycle.
- Input priority per cycle: btn_clear > btn_start > btn_inc_sec/btn_inc_min.
- IDLE:
  - btn_inc_sec: seconds +1 BCD, 59 wraps to 00, no carry into minutes.
  - btn_inc_min: minutes +1, 59 wraps to 00.
  - btn_inc_sec and btn_inc_min in the same cycle: both apply.
  - btn_start with time != 00:00: go to RUN.
  - btn_start with time == 00:00: ignored.
  - btn_clear: digits 0.
  - clk_sec: ignored.
- RUN:
  - On clk_sec, decrement mm:ss with BCD borrow. Examples: 10:00 -> 09:59, 01:00 -> 00:59.
  - If the decrement produces 00:00, go to ALARM on that same edge and load the alarm counter with 0.
  - btn_start: go to PAUSE. If clk_sec arrives in the same cycle, the decrement is still applied. If that decrement reaches 00:00, ALARM wins over PAUSE.
  - btn_clear: digits 0, go to IDLE, tick discarded.
  - Inc buttons: ignored.
- PAUSE:
  - Digits frozen; clk_sec ignored.
  - btn_start: go to RUN.
  - btn_clear: digits 0, go to IDLE.
  - Inc buttons: ignored.
- ALARM:
  - alarm=1; digits held at 00:00.
  - Each clk_sec increments the alarm counter.
  - When the counter reaches ALARM_SEC-1 and a clk_sec occurs, go to IDLE. Alarm is therefore high for ALARM_SEC ticks.
  - Any button pulse (start, inc, clear) goes to IDLE immediately and is otherwise consumed. An inc does not modify the digits on that edge.
- running = (state==RUN). alarm = (state==ALARM). Both are decoded from the registered state, with no glitches.
- Digits never leave the legal BCD range. Out-of-range values are unreachable; no recovery logic is required.

Decomposition:
- Shared package, clock_pkg:
  - State encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_ALARM=2'd3.
  - BCD limits: BCD_MAX1=4'd9, BCD_MAX10=4'd5.
- One sub-module, bcd_mmss_updown:
  - Holds the four digits.
  - Has clear, dec (with borrow), inc_sec and inc_min (no carry) controls.
  - Outputs a zero_next flag indicating the decrement will yield 00:00.
- The FSM and alarm counter live in countdown_timer_ctrl.

Test Plan:
- Reset then set: 3x btn_inc_min, 5x btn_inc_sec -> digits 03:05, state IDLE, running 0.
- Wrap: 60x btn_inc_sec from 00:00 -> 00:00 with minutes unchanged; 59 then +1 min -> min 00.
- Countdown/borrow: load 01:00, btn_start, 1 clk_sec -> 00:59, running 1; 59 more ticks -> 00:00, state ALARM, alarm 1; ALARM_SEC=10 ticks later -> IDLE, alarm 0.
- Pause: RUN at 00:30, btn_start -> PAUSE; 5 clk_sec -> still 00:30; btn_start -> RUN; next tick -> 00:29.
- Simultaneous: RUN at 00:01, btn_start and clk_sec in the same cycle -> ALARM (not PAUSE). RUN at 00:20, btn_clear and clk_sec together -> IDLE, 00:00.
- Edge cases: btn_start at 00:00 in IDLE -> stays IDLE. btn_inc_sec during ALARM -> IDLE, digits 00:00. reset_n low mid-RUN at 02:15 -> immediate 00:00, IDLE, all flags 0.
